// File: rtl/jtkcpu_intseq.sv
// Interrupt entry sequencer: arbitrates NMI/FIRQ/IRQ at instruction boundaries,
// drives the push/pull unit, strobes the CC bits, then fetches the vector into PC.
module jtkcpu_intseq #(
    parameter logic [15:0] NMI_VEC  = 16'hFFFC,
    parameter logic [15:0] FIRQ_VEC = 16'hFFF6,
    parameter logic [15:0] IRQ_VEC  = 16'hFFF8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        nmi_n,
    input  logic        firq_n,
    input  logic        irq_n,
    input  logic        insn_end,
    input  logic        cc_f,
    input  logic        cc_i,
    input  logic        psh_idle,
    input  logic [7:0]  din,
    input  logic        din_ok,
    output logic        int_busy,
    output logic        psh_go,
    output logic [7:0]  postbyte,
    output logic        us_sel,
    output logic        set_e,
    output logic        clr_e,
    output logic        set_i,
    output logic        set_f,
    output logic        vec_rd,
    output logic [15:0] vec_addr,
    output logic        pc_ld,
    output logic [15:0] pc_nx
);

    typedef enum logic [2:0] {IDLE, PUSH, GAP, WAITP, VHI, VLO} state_t;
    typedef enum logic [1:0] {SRC_NMI, SRC_FIRQ, SRC_IRQ} src_t;

    state_t      state, state_nx;
    src_t        src, src_nx;
    logic [7:0]  pb_r, pb_nx;
    logic [7:0]  vec_hi, hi_nx;
    logic        first, first_nx;
    logic        nmi_l, nmi_pend, take_nmi;
    logic [15:0] vec_base;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            src      <= SRC_IRQ;
            pb_r     <= 8'h00;
            vec_hi   <= 8'h00;
            first    <= 1'b0;
            nmi_l    <= nmi_n;  // a line held low through reset is not an edge
            nmi_pend <= 1'b0;
        end else begin
            state    <= state_nx;
            src      <= src_nx;
            pb_r     <= pb_nx;
            vec_hi   <= hi_nx;
            first    <= first_nx;
            nmi_l    <= nmi_n;
            // a fresh edge wins over the clear so it is never lost
            nmi_pend <= (nmi_pend & ~take_nmi) | (nmi_l & ~nmi_n);
        end
    end

    always_comb begin
        state_nx = state;
        src_nx   = src;
        pb_nx    = pb_r;
        hi_nx    = vec_hi;
        first_nx = first;
        take_nmi = 1'b0;
        case (state)
            IDLE: begin
                if (insn_end) begin
                    if (nmi_pend) begin
                        src_nx   = SRC_NMI;
                        pb_nx    = 8'hFF;
                        take_nmi = 1'b1;
                        state_nx = PUSH;
                    end else if (!firq_n && !cc_f) begin
                        src_nx   = SRC_FIRQ;
                        pb_nx    = 8'h81;
                        state_nx = PUSH;
                    end else if (!irq_n && !cc_i) begin
                        src_nx   = SRC_IRQ;
                        pb_nx    = 8'hFF;
                        state_nx = PUSH;
                    end
                end
            end
            PUSH:  state_nx = GAP;
            GAP:   state_nx = WAITP;
            WAITP: begin
                if (psh_idle) begin
                    state_nx = VHI;
                    first_nx = 1'b1;
                end
            end
            VHI: begin
                first_nx = 1'b0;
                if (din_ok) begin
                    hi_nx    = din;
                    state_nx = VLO;
                end
            end
            VLO: begin
                if (din_ok) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        case (src)
            SRC_NMI:  vec_base = NMI_VEC;
            SRC_FIRQ: vec_base = FIRQ_VEC;
            default:  vec_base = IRQ_VEC;
        endcase
    end

    // Strobes are masked by rst so that a reset cycle can never fire one.
    always_comb begin
        int_busy = 1'b0;
        psh_go   = 1'b0;
        set_e    = 1'b0;
        clr_e    = 1'b0;
        set_i    = 1'b0;
        set_f    = 1'b0;
        vec_rd   = 1'b0;
        vec_addr = 16'h0000;
        pc_ld    = 1'b0;
        pc_nx    = 16'h0000;
        postbyte = pb_r;
        us_sel   = 1'b1;
        if (!rst) begin
            int_busy = (state != IDLE);
            case (state)
                PUSH: begin
                    psh_go = 1'b1;
                    set_e  = (src != SRC_FIRQ);
                    clr_e  = (src == SRC_FIRQ);
                end
                VHI: begin
                    vec_rd   = 1'b1;
                    vec_addr = vec_base;
                    set_i    = first;
                    set_f    = first & (src != SRC_IRQ);
                end
                VLO: begin
                    vec_rd   = 1'b1;
                    vec_addr = vec_base + 16'd1;
                    pc_ld    = din_ok;
                    if (din_ok) pc_nx = {vec_hi, din};
                end
                default: ;
            endcase
        end
    end

endmodule
